// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI transfer controller: FSM states,
// spi_if descriptor bit positions, cfg word layout and FIFO sizing.
package spi_ctrl_pkg;

   localparam int FIFO_DEPTH = 16;
   localparam int CNT_W      = 5;
   localparam int CFG_W      = 11;

   // Descriptor flags in the 11-bit spi_if data word
   localparam int DESC_START = 8;
   localparam int DESC_STOP  = 9;
   localparam int DESC_RX    = 10;

   // cfg command word fields
   localparam int CFG_CPHA      = 0;
   localparam int CFG_CPOL      = 1;
   localparam int CFG_LSB_FIRST = 2;
   localparam int CFG_BAUD_LSB  = 3;
   localparam int CFG_BAUD_MSB  = 10;

   localparam int DOUT_EMPTY = 8;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CFG,
      ST_CFG_ACK,
      ST_TX_FETCH,
      ST_WR,
      ST_WR_ACK,
      ST_RD,
      ST_RD_ACK,
      ST_DONE
   } state_t;

   function automatic logic [CFG_W-1:0] wr_desc(input logic rx, input logic last,
                                                input logic first, input logic [7:0] data);
      logic [CFG_W-1:0] d;
      d              = {3'b000, data};
      d[DESC_RX]     = rx;
      d[DESC_STOP]   = last;
      d[DESC_START]  = first;
      return d;
   endfunction

   function automatic logic [CFG_W-1:0] make_cfg(input logic [7:0] baud, input logic lsb_first,
                                                 input logic cpol, input logic cpha);
      logic [CFG_W-1:0] c;
      c                              = '0;
      c[CFG_BAUD_MSB:CFG_BAUD_LSB]   = baud;
      c[CFG_LSB_FIRST]               = lsb_first;
      c[CFG_CPOL]                    = cpol;
      c[CFG_CPHA]                    = cpha;
      return c;
   endfunction

endpackage

// File: rtl/spi_xfer_ctrl.sv
// Sequences one SPI transfer through spi_if: optional cfg command, then the
// TX bytes as framed write descriptors, then optional reads of MISO bytes.
module spi_xfer_ctrl
   import spi_ctrl_pkg::*;
#(
   parameter int MAX_LEN = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [CFG_W-1:0] req_cfg,
   input  logic [3:0]       req_len,
   input  logic             req_rx,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic [7:0]       tx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic [7:0]       rx_data,
   output logic             busy,
   output logic             done,
   output logic [CFG_W-1:0] if_din,
   output logic             if_cmd,
   output logic             if_wr,
   output logic             if_rd,
   input  logic [8:0]       if_dout,
   input  logic             if_ack
);

   localparam int               LEN_CAP = (MAX_LEN < FIFO_DEPTH) ? MAX_LEN : FIFO_DEPTH;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LEN_CAP);

   state_t           state, state_nxt;
   logic [CFG_W-1:0] cfg_q, last_cfg;
   logic             cfg_known;
   logic [3:0]       len_q;
   logic             rx_q;
   logic [7:0]       tx_byte;
   logic [CNT_W-1:0] wcount, rcount;
   logic [CNT_W-1:0] len_ext;

   assign len_ext = {1'b0, len_q};
   assign busy    = (state != ST_IDLE);
   assign done    = (state == ST_DONE);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt = state;
      req_ready = 1'b0;
      tx_ready  = 1'b0;
      if_cmd    = 1'b0;
      if_wr     = 1'b0;
      if_rd     = 1'b0;
      if_din    = '0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid)
               state_nxt = (cfg_known && req_cfg == last_cfg) ? ST_TX_FETCH : ST_CFG;
         end
         ST_CFG: begin
            if_cmd    = 1'b1;
            if_din    = cfg_q;
            state_nxt = ST_CFG_ACK;
         end
         ST_CFG_ACK: if (if_ack) state_nxt = ST_TX_FETCH;
         ST_TX_FETCH: begin
            tx_ready = 1'b1;
            if (tx_valid) state_nxt = ST_WR;
         end
         ST_WR: begin
            if_wr     = 1'b1;
            if_din    = wr_desc(rx_q, wcount == len_ext, wcount == '0, tx_byte);
            state_nxt = ST_WR_ACK;
         end
         ST_WR_ACK: begin
            // No ack means the write FIFO was full; resend the same descriptor
            if (!if_ack)              state_nxt = ST_WR;
            else if (wcount < len_ext) state_nxt = ST_TX_FETCH;
            else if (rx_q)             state_nxt = ST_RD;
            else                       state_nxt = ST_DONE;
         end
         ST_RD: begin
            if (!rx_valid || rx_ready) begin
               if_rd     = 1'b1;
               state_nxt = ST_RD_ACK;
            end
         end
         ST_RD_ACK: begin
            if (if_ack) state_nxt = (rcount == len_ext + 5'd1) ? ST_DONE : ST_RD;
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cfg_q     <= '0;
         last_cfg  <= '0;
         cfg_known <= 1'b0;
         len_q     <= '0;
         rx_q      <= 1'b0;
         tx_byte   <= '0;
         wcount    <= '0;
         rcount    <= '0;
         rx_valid  <= 1'b0;
         rx_data   <= '0;
      end else begin
         state <= state_nxt;

         if (state == ST_IDLE && req_valid) begin
            cfg_q  <= req_cfg;
            len_q  <= req_len;
            rx_q   <= req_rx;
            wcount <= '0;
            rcount <= '0;
         end

         if (state == ST_CFG_ACK && if_ack) begin
            cfg_known <= 1'b1;
            last_cfg  <= cfg_q;
         end

         if (tx_ready && tx_valid) tx_byte <= tx_data;

         if (state == ST_WR_ACK && if_ack && wcount != CNT_MAX) wcount <= wcount + 1'b1;

         // A reload in the same cycle as a consume must win, so it comes last
         if (rx_ready) rx_valid <= 1'b0;
         if (if_rd && !if_dout[DOUT_EMPTY]) begin
            rx_data  <= if_dout[7:0];
            rx_valid <= 1'b1;
            if (rcount != CNT_MAX) rcount <= rcount + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a small spi_if model (registered ack,
// write-FIFO-full injection, read FIFO with injected empty polls).
module tb_spi_xfer_ctrl;
   import spi_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_rx;
   logic [10:0] req_cfg;
   logic [3:0]  req_len;
   logic        tx_valid, tx_ready;
   logic [7:0]  tx_data;
   logic        rx_valid, rx_ready;
   logic [7:0]  rx_data;
   logic        busy, done;
   logic [10:0] if_din;
   logic        if_cmd, if_wr, if_rd;
   logic [8:0]  if_dout;
   logic        if_ack;

   spi_xfer_ctrl #(.MAX_LEN(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_cfg(req_cfg),
      .req_len(req_len), .req_rx(req_rx),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
      .busy(busy), .done(done),
      .if_din(if_din), .if_cmd(if_cmd), .if_wr(if_wr), .if_rd(if_rd),
      .if_dout(if_dout), .if_ack(if_ack)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- spi_if model and TX source ----------------
   int          cyc = 0;
   int          tx_taken = 0, tx_mark = 0;
   logic [7:0]  tx_base = 8'h00;
   int          wr_full_seen = 0, full_target = 0;
   int          polls_done = 0, poll_target = 0;
   int          rd_idx = 0, miso_wr = 0;
   logic [7:0]  miso_mem [0:63];

   assign tx_data = tx_base + 8'(tx_taken - tx_mark);
   assign if_dout = (polls_done < poll_target || rd_idx >= miso_wr) ? 9'h100
                                                                    : {1'b0, miso_mem[rd_idx[5:0]]};

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (tx_valid && tx_ready) tx_taken <= tx_taken + 1;
      if (rst) begin
         if_ack <= 1'b0;
      end else begin
         if_ack <= 1'b0;
         if (if_cmd) if_ack <= 1'b1;
         if (if_wr) begin
            if (wr_full_seen < full_target) wr_full_seen <= wr_full_seen + 1;
            else                            if_ack <= 1'b1;
         end
         if (if_rd) begin
            if_ack <= 1'b1;
            if (polls_done < poll_target) polls_done <= polls_done + 1;
            else if (rd_idx < miso_wr)    rd_idx <= rd_idx + 1;
         end
      end
   end

   // ---------------- monitor (samples mid-cycle) ----------------
   int          cmd_n = 0, rd_n = 0, done_n = 0, viol = 0;
   int          last_wr_cyc = 0, last_rd_cyc = 0, done_cyc = 0;
   logic [10:0] cmd_din = '0;
   logic [10:0] wr_log [$];
   logic [7:0]  rx_log [$];

   always @(negedge clk) begin
      if (if_cmd) begin cmd_n++; cmd_din = if_din; end
      if (if_wr)  begin wr_log.push_back(if_din); last_wr_cyc = cyc; end
      if (if_rd)  begin
         rd_n++;
         last_rd_cyc = cyc;
         if (rx_valid && !rx_ready) viol++;
      end
      if (done) begin done_n++; done_cyc = cyc; end
      if ((int'(if_cmd) + int'(if_wr) + int'(if_rd)) > 1) viol++;
      if (!(if_cmd || if_wr || if_rd) && if_din != '0) viol++;
      if (rx_valid && rx_ready) rx_log.push_back(rx_data);
   end

   // ---------------- helpers ----------------
   int m_cmd, m_wr, m_rd, m_done, m_tx, m_rx;

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_xfer(input logic [10:0] cfg, input logic [3:0] len, input logic rx,
                             input logic [7:0] tx0, input int full_n);
      m_cmd = cmd_n; m_wr = wr_log.size(); m_rd = rd_n; m_done = done_n;
      m_tx = tx_taken; m_rx = rx_log.size();
      tx_base = tx0; tx_mark = tx_taken; full_target = wr_full_seen + full_n;
      req_cfg = cfg; req_len = len; req_rx = rx; req_valid = 1'b1;
      check("req_ready_idle", req_ready, 1);
      step(1);
      req_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done && n < budget) begin
         step(1);
         n++;
      end
      check("done_seen", done, 1);
      step(1);
   endtask

   task automatic load_miso(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int n);
      logic [7:0] b [3];
      b[0] = b0; b[1] = b1; b[2] = b2;
      for (int k = 0; k < n; k++) miso_mem[(miso_wr + k) % 64] = b[k];
      miso_wr = miso_wr + n;
   endtask

   typedef struct {
      logic [10:0] cfg;
      logic [3:0]  len;
      logic [7:0]  tx0;
      int          full_n;
      int          exp_cmd;
      int          exp_wr;
      logic [10:0] exp_first;
      logic [10:0] exp_mid;
      logic [10:0] exp_last;
   } vec_t;

   vec_t vecs [6];

   initial begin
      vec_t v;
      int   n;

      vecs[0] = '{11'h00A, 4'd0,  8'h5A, 0, 1, 1,  11'h35A, 11'h000, 11'h35A};
      vecs[1] = '{11'h00A, 4'd2,  8'h10, 0, 0, 3,  11'h110, 11'h011, 11'h212};
      vecs[2] = '{11'h00A, 4'd0,  8'h77, 3, 0, 4,  11'h377, 11'h000, 11'h377};
      vecs[3] = '{11'h155, 4'd0,  8'h01, 0, 1, 1,  11'h301, 11'h000, 11'h301};
      vecs[4] = '{11'h155, 4'd15, 8'h20, 0, 0, 16, 11'h120, 11'h000, 11'h22F};
      vecs[5] = '{11'h00A, 4'd1,  8'hE0, 0, 1, 2,  11'h1E0, 11'h000, 11'h2E1};

      rst = 1'b1; req_valid = 1'b0; req_cfg = '0; req_len = '0; req_rx = 1'b0;
      tx_valid = 1'b1; rx_ready = 1'b1;
      step(3);
      check("rst_busy",     busy, 0);
      check("rst_done",     done, 0);
      check("rst_tx_ready", tx_ready, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data",  rx_data, 0);
      check("rst_strobes",  {if_cmd, if_wr, if_rd}, 0);
      check("rst_din",      if_din, 0);
      rst = 1'b0;
      step(2);

      // Write-only transfers from the vector table
      for (int i = 0; i < 6; i++) begin
         v = vecs[i];
         start_xfer(v.cfg, v.len, 1'b0, v.tx0, v.full_n);
         wait_done(400);
         check($sformatf("v%0d_cmd_n", i), cmd_n - m_cmd, v.exp_cmd);
         if (v.exp_cmd == 1) check($sformatf("v%0d_cmd_din", i), cmd_din, v.cfg);
         check($sformatf("v%0d_wr_n", i), wr_log.size() - m_wr, v.exp_wr);
         check($sformatf("v%0d_din_first", i), wr_log[m_wr], v.exp_first);
         if (v.exp_wr == 3) check($sformatf("v%0d_din_mid", i), wr_log[m_wr + 1], v.exp_mid);
         check($sformatf("v%0d_din_last", i), wr_log[wr_log.size() - 1], v.exp_last);
         check($sformatf("v%0d_tx_taken", i), tx_taken - m_tx, 32'(v.len) + 1);
         check($sformatf("v%0d_done_n", i), done_n - m_done, 1);
         check($sformatf("v%0d_done_lat", i), done_cyc - last_wr_cyc, 2);
         check($sformatf("v%0d_idle", i), busy, 0);
      end

      // Read transfer: two empty polls, then 0xC3, 0x3C
      load_miso(8'hC3, 8'h3C, 8'h00, 2);
      poll_target = polls_done + 2;
      start_xfer(11'h00A, 4'd1, 1'b1, 8'hA0, 0);
      wait_done(400);
      check("rd_cmd_n",     cmd_n - m_cmd, 0);
      check("rd_din0",      wr_log[m_wr], 11'h5A0);
      check("rd_din1",      wr_log[m_wr + 1], 11'h6A1);
      check("rd_strobes",   rd_n - m_rd, 4);
      check("rd_rx_n",      rx_log.size() - m_rx, 2);
      check("rd_rx0",       rx_log[m_rx], 8'hC3);
      check("rd_rx1",       rx_log[m_rx + 1], 8'h3C);
      check("rd_done_n",    done_n - m_done, 1);
      check("rd_done_lat",  done_cyc - last_rd_cyc, 2);

      // Consumer stall: no read strobes while a byte is held, stray req ignored
      load_miso(8'h11, 8'h22, 8'h33, 3);
      rx_ready = 1'b0;
      start_xfer(11'h00A, 4'd2, 1'b1, 8'hB0, 0);
      n = 0;
      while (!rx_valid && n < 200) begin step(1); n++; end
      check("stall_rx_valid_rise", rx_valid, 1);
      n = rd_n;
      req_cfg = 11'h7FF; req_valid = 1'b1;
      step(1);
      req_valid = 1'b0;
      step(9);
      check("stall_no_rd",   rd_n - n, 0);
      check("stall_held",    rx_valid, 1);
      check("stall_data",    rx_data, 8'h11);
      rx_ready = 1'b1;
      wait_done(400);
      check("stall_rx_n",    rx_log.size() - m_rx, 3);
      check("stall_rx0",     rx_log[m_rx], 8'h11);
      check("stall_rx1",     rx_log[m_rx + 1], 8'h22);
      check("stall_rx2",     rx_log[m_rx + 2], 8'h33);
      step(4);
      check("stray_req_busy", busy, 0);
      check("stray_req_cmd",  cmd_n - m_cmd, 0);
      check("stall_done_n",   done_n - m_done, 1);

      // Reset during WR_ACK of byte 3 of an 8-byte transfer
      start_xfer(make_cfg(8'h1E, 1'b0, 1'b0, 1'b0), 4'd7, 1'b0, 8'h30, 0);
      n = 0;
      for (int k = 0; k < 300 && n < 4; k++) begin
         step(1);
         if (if_wr) n++;
      end
      check("mid_wr_seen", n, 4);
      check("mid_din3",    if_din, 11'h033);
      step(1);
      rst = 1'b1;
      step(1);
      check("mid_rst_busy",   busy, 0);
      check("mid_rst_ready",  req_ready, 1);
      check("mid_rst_strobe", {if_cmd, if_wr, if_rd}, 0);
      check("mid_rst_done",   done, 0);
      rst = 1'b0;
      step(5);
      check("mid_no_done", done_n - m_done, 0);
      start_xfer(11'h0F0, 4'd0, 1'b0, 8'h44, 0);
      wait_done(400);
      check("mid_recmd_n",   cmd_n - m_cmd, 1);
      check("mid_recmd_din", cmd_din, 11'h0F0);
      check("mid_re_din",    wr_log[wr_log.size() - 1], 11'h344);

      check("strobe_rules", viol, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_xfer_ctrl.md
SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, maximum bytes per transfer; must not exceed the spi_if read FIFO depth.
REQ-002 SHALL have ports (clk and rst first):
 clk  in  1  clock
 rst  in  1  reset, synchronous, active-high
 req_valid  in  1  transfer request
 req_ready  out  1  high only in IDLE
 req_cfg  in  11  {baud[7:0], lsb_first, cpol, cpha}, spi_if cmd word
 req_len  in  4  byte count minus 1 (0 = 1 byte, 15 = 16 bytes)
 req_rx  in  1  capture MISO bytes
 tx_valid  in  1  TX byte available
 tx_ready  out  1  TX byte taken
 tx_data  in  8  TX byte
 rx_valid  out  1  RX byte held
 rx_ready  in  1  RX byte consumed
 rx_data  out  8  RX byte
 busy  out  1  state != IDLE
 done  out  1  one-cycle pulse at transfer end
 if_din  out  11  to spi_if din
 if_cmd  out  1  to spi_if cmd
 if_wr  out  1  to spi_if wr
 if_rd  out  1  to spi_if rd
 if_dout  in  9  from spi_if; bit 8 = read FIFO empty
 if_ack  in  1  from spi_if; registered, one cycle after strobe

Function
REQ-003 SHALL implement FSM states IDLE, CFG, CFG_ACK, TX_FETCH, WR, WR_ACK, RD, RD_ACK, DONE.
REQ-004 IDLE: on req_valid, latch cfg/len/rx; go to CFG if cfg_known=0 or req_cfg differs from last issued cfg, else go to TX_FETCH.
REQ-005 CFG: assert if_cmd for exactly 1 cycle with if_din=cfg, then go to CFG_ACK; CFG_ACK: wait for if_ack, set cfg_known, store cfg, go to TX_FETCH.
REQ-006 TX_FETCH: tx_ready=1; on tx_valid, latch tx_data and go to WR.
REQ-007 WR: assert if_wr for 1 cycle with if_din={rx, last, first, byte}; first=1 only for byte 0, last=1 only for byte len; if_din[10] is rx on every byte.
REQ-008 WR_ACK (exactly 1 cycle): if_ack=1 -> increment wcount, then go to TX_FETCH if bytes remain, else RD if rx, else DONE; if_ack=0 (write FIFO full) -> go to WR and retry the same byte.
REQ-009 RD: strobe if_rd for 1 cycle only when rx_valid=0 or rx_ready=1, else hold without strobing; sample if_dout in the strobe cycle.
REQ-010 On an RD strobe with if_dout[8]=0, SHALL load rx_data=if_dout[7:0], set rx_valid, and increment rcount; with if_dout[8]=1, SHALL discard the sample.
REQ-011 RD_ACK: wait for if_ack, then go to DONE if rcount=len+1, else RD.
REQ-012 DONE: done=1 for 1 cycle, then go to IDLE.
REQ-013 rx_valid SHALL clear on rx_ready unless reloaded in the same cycle; rx_valid may remain set through DONE/IDLE.
REQ-014 Only one of if_cmd/if_wr/if_rd SHALL be high in any cycle; if_din=0 when no strobe is high.
REQ-015 Counters SHALL be 5 bits wide and SHALL NOT wrap (max 16).
REQ-016 req_valid outside IDLE and tx_valid outside TX_FETCH SHALL be ignored.

Reset
REQ-017 On rst, state=IDLE, all strobes=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0, done=0, counters=0, cfg_known=0; this takes effect mid-transfer with no completion pulse.

Structure
REQ-018 Package spi_ctrl_pkg SHALL hold the state enum, descriptor bit indices (START=8, STOP=9, RX=10), cfg field positions, and the FIFO depth constant 16.
REQ-019 The block SHALL be a single module with no sub-modules; spi_if is instantiated by the parent.

Verification (bench models spi_if ack/FIFO timing)
REQ-020 Reset, then req cfg=0x00A, len=0, rx=0, tx 0x5A -> one if_cmd with din=0x00A, one if_wr with din=0x35A, done one cycle after WR_ACK.
REQ-021 Repeat the same cfg with len=2 -> no if_cmd; din sequence 0x1xx, 0x0xx, 0x2xx.
REQ-022 Model write FIFO full for 3 strobes -> exactly 4 if_wr pulses for the byte, wcount advances once.
REQ-023 rx=1, len=1, MISO 0xC3, 0x3C with 2 empty polls first -> rx_data 0xC3 then 0x3C, done after the second.
REQ-024 Hold rx_ready=0 for 10 cycles -> no if_rd while rx_valid=1, no byte lost.
REQ-025 Assert rst in WR_ACK of byte 3 of 8 -> IDLE next cycle, no done, next request reissues if_cmd.
